// File: rtl/rv_pkg.sv
// Shared core definitions: register-file geometry, x0 constant and the
// writeback entry layout used by the writeback path.
package rv_pkg;

   localparam int REG_AW = 5;
   localparam int XLEN   = 32;
   localparam int NREGS  = 1 << REG_AW;

   localparam logic [REG_AW-1:0] REG_X0 = 5'd0;

   // One pending register-file write: destination and value.
   typedef struct packed {
      logic [REG_AW-1:0] rd;
      logic [XLEN-1:0]   data;
   } wb_entry_t;

   // Writes and scoreboard updates aimed at x0 are architecturally void.
   function automatic logic is_x0(input logic [REG_AW-1:0] rd);
      return (rd == REG_X0);
   endfunction

endpackage

// File: rtl/wb_fifo.sv
// In-order buffer for load-path writeback entries.
// Pointers carry one extra wrap bit so full and empty are told apart
// without a separate counter. Both flags are registered so that the
// upstream ready depends only on flop outputs.
module wb_fifo
   import rv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int WIDTH = REG_AW + XLEN
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             i_push,
   input  logic [WIDTH-1:0] i_data,
   input  logic             i_pop,
   output logic [WIDTH-1:0] o_data,
   output logic             o_full,
   output logic             o_empty
);

   localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

   logic [WIDTH-1:0] r_mem [DEPTH];
   logic [AW:0]      r_wr_ptr;
   logic [AW:0]      r_rd_ptr;
   logic             r_full;
   logic             r_empty;

   logic             w_push;
   logic             w_pop;
   logic [AW:0]      w_wr_ptr_nxt;
   logic [AW:0]      w_rd_ptr_nxt;

   // A full buffer never takes a push, even in a cycle that also pops.
   assign w_push = i_push & ~r_full;
   assign w_pop  = i_pop & ~r_empty;

   // Next pointer values feed the registered flag computation.
   always_comb begin
      w_wr_ptr_nxt = r_wr_ptr;
      w_rd_ptr_nxt = r_rd_ptr;
      if (w_push) w_wr_ptr_nxt = r_wr_ptr + {{AW{1'b0}}, 1'b1};
      if (w_pop)  w_rd_ptr_nxt = r_rd_ptr + {{AW{1'b0}}, 1'b1};
   end

   // Pointer and flag registers; reset discards any buffered entries.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_full   <= 1'b0;
         r_empty  <= 1'b1;
      end else begin
         r_wr_ptr <= w_wr_ptr_nxt;
         r_rd_ptr <= w_rd_ptr_nxt;
         r_full   <= (w_wr_ptr_nxt[AW] != w_rd_ptr_nxt[AW]) &&
                     (w_wr_ptr_nxt[AW-1:0] == w_rd_ptr_nxt[AW-1:0]);
         r_empty  <= (w_wr_ptr_nxt == w_rd_ptr_nxt);
      end
   end

   // Storage needs no reset: the empty flag guards every read.
   always_ff @(posedge clk) begin
      if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
   end

   assign o_data  = r_mem[r_rd_ptr[AW-1:0]];
   assign o_full  = r_full;
   assign o_empty = r_empty;

endmodule

// File: rtl/reg_wb_unit.sv
// Writeback unit: sole driver of the register file write port.
// Merges the never-stalled ALU result with buffered load results (ALU
// has fixed priority) and tracks which registers still await a
// long-latency result so decode can stall on them.
//
// Load handshake: a beat transfers on a rising edge where mem_valid and
// mem_ready are both high. mem_ready is the inverse of the registered
// buffer-full flag (held low while in reset and until the first edge
// after release); it never looks at a same-cycle pop.
module reg_wb_unit
   import rv_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int XLEN  = rv_pkg::XLEN
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              alu_valid,
   input  logic [4:0]        alu_rd,
   input  logic [XLEN-1:0]   alu_data,
   input  logic              mem_valid,
   output logic              mem_ready,
   input  logic [4:0]        mem_rd,
   input  logic [XLEN-1:0]   mem_data,
   input  logic              issue_valid,
   input  logic [4:0]        issue_rd,
   input  logic [4:0]        chk_a1,
   input  logic [4:0]        chk_a2,
   output logic              hazard_a1,
   output logic              hazard_a2,
   output logic              WE3,
   output logic [4:0]        A3,
   output logic [XLEN-1:0]   WD3
);

   localparam int EW = REG_AW + XLEN;

   logic              r_live;
   logic              r_we;
   logic [4:0]        r_a3;
   logic [XLEN-1:0]   r_wd;
   logic [NREGS-1:0]  r_pending;

   logic              w_full;
   logic              w_empty;
   logic              w_push;
   logic              w_pop;
   logic [EW-1:0]     w_head;
   logic [4:0]        w_head_rd;
   logic [XLEN-1:0]   w_head_data;
   logic [NREGS-1:0]  w_set_mask;
   logic [NREGS-1:0]  w_clr_mask;
   logic [NREGS-1:0]  w_pending_nxt;

   // ------------------------------------------------------------------
   // Load buffer
   // ------------------------------------------------------------------
   assign mem_ready = r_live & ~w_full;
   assign w_push    = mem_valid & mem_ready;
   // The buffer drains only in cycles the ALU leaves the port free.
   assign w_pop     = ~alu_valid & ~w_empty;

   wb_fifo #(
      .DEPTH (DEPTH),
      .WIDTH (EW)
   ) u_fifo (
      .clk     (clk),
      .rst_n   (rst),
      .i_push  (w_push),
      .i_data  ({mem_rd, mem_data}),
      .i_pop   (w_pop),
      .o_data  (w_head),
      .o_full  (w_full),
      .o_empty (w_empty)
   );

   assign w_head_rd   = w_head[EW-1:XLEN];
   assign w_head_data = w_head[XLEN-1:0];

   // Ready stays low during reset and comes up on the first edge after.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_live <= 1'b0;
      else      r_live <= 1'b1;
   end

   // ------------------------------------------------------------------
   // Arbiter and write-port register
   // ------------------------------------------------------------------
   // ALU first, then buffer head; an x0 destination is consumed with WE3 low.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_we <= 1'b0;
         r_a3 <= '0;
         r_wd <= '0;
      end else if (alu_valid) begin
         r_we <= ~is_x0(alu_rd);
         r_a3 <= alu_rd;
         r_wd <= alu_data;
      end else if (w_pop) begin
         r_we <= ~is_x0(w_head_rd);
         r_a3 <= w_head_rd;
         r_wd <= w_head_data;
      end else begin
         r_we <= 1'b0;
      end
   end

   assign WE3 = r_we;
   assign A3  = r_a3;
   assign WD3 = r_wd;

   // ------------------------------------------------------------------
   // Pending scoreboard
   // ------------------------------------------------------------------
   // Set on issue, clear on the pop that writes the result; set wins a tie.
   // ALU writes leave the pending bits alone.
   always_comb begin
      w_set_mask = '0;
      w_clr_mask = '0;
      if (issue_valid && !is_x0(issue_rd)) w_set_mask[issue_rd] = 1'b1;
      if (w_pop) w_clr_mask[w_head_rd] = 1'b1;
      w_pending_nxt = ((r_pending & ~w_clr_mask) | w_set_mask) &
                      ~{{(NREGS-1){1'b0}}, 1'b1};
   end

   // Scoreboard register; reset forgets every outstanding result.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) r_pending <= '0;
      else      r_pending <= w_pending_nxt;
   end

   // Combinational lookup for decode; x0 never reports a hazard.
   assign hazard_a1 = r_pending[chk_a1] & ~is_x0(chk_a1);
   assign hazard_a2 = r_pending[chk_a2] & ~is_x0(chk_a2);

endmodule

// File: tb/tb_reg_wb_unit.sv
// Directed bench for reg_wb_unit with a write-port scoreboard.
module tb_reg_wb_unit;

   localparam int DEPTH = 2;
   localparam int XLEN  = 32;
   localparam int W     = 5 + XLEN;

   logic            clk = 1'b0;
   logic            rst;
   logic            alu_valid;
   logic [4:0]      alu_rd;
   logic [XLEN-1:0] alu_data;
   logic            mem_valid;
   logic            mem_ready;
   logic [4:0]      mem_rd;
   logic [XLEN-1:0] mem_data;
   logic            issue_valid;
   logic [4:0]      issue_rd;
   logic [4:0]      chk_a1;
   logic [4:0]      chk_a2;
   logic            hazard_a1;
   logic            hazard_a2;
   logic            WE3;
   logic [4:0]      A3;
   logic [XLEN-1:0] WD3;

   int checks   = 0;
   int failures = 0;

   logic [W-1:0] exp_q[$];
   logic [W-1:0] m_buf[$];
   logic         m_live;
   logic         m_acc;
   logic         m_has;
   logic [W-1:0] m_w;
   logic [W-1:0] got;

   reg_wb_unit #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
      .clk         (clk),
      .rst         (rst),
      .alu_valid   (alu_valid),
      .alu_rd      (alu_rd),
      .alu_data    (alu_data),
      .mem_valid   (mem_valid),
      .mem_ready   (mem_ready),
      .mem_rd      (mem_rd),
      .mem_data    (mem_data),
      .issue_valid (issue_valid),
      .issue_rd    (issue_rd),
      .chk_a1      (chk_a1),
      .chk_a2      (chk_a2),
      .hazard_a1   (hazard_a1),
      .hazard_a2   (hazard_a2),
      .WE3         (WE3),
      .A3          (A3),
      .WD3         (WD3)
   );

   // clock / reset
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not reach the end");
      $fatal(1, "watchdog");
   end

   // reference model: fixed-priority merge, DEPTH-entry in-order buffer
   always @(posedge clk or negedge rst) begin
      if (!rst) begin
         exp_q.delete();
         m_buf.delete();
         m_live = 1'b0;
      end else begin
         m_acc = m_live && mem_valid && (m_buf.size() < DEPTH);
         m_has = 1'b0;
         m_w   = '0;
         if (alu_valid) begin
            m_w   = {alu_rd, alu_data};
            m_has = 1'b1;
         end else if (m_buf.size() > 0) begin
            m_w   = m_buf.pop_front();
            m_has = 1'b1;
         end
         if (m_has && (m_w[W-1:XLEN] != 5'd0)) exp_q.push_back(m_w);
         if (m_acc) m_buf.push_back({mem_rd, mem_data});
         m_live = 1'b1;
      end
   end

   // scoreboard: every observed write must be the next expected one
   always @(negedge clk) begin
      if (rst && WE3) begin
         checks++;
         assert (exp_q.size() != 0) else begin
            failures++;
            $error("FAIL wb_unexpected observed rd=%0d data=%h expected no write", A3, WD3);
         end
         if (exp_q.size() != 0) begin
            got = exp_q.pop_front();
            checks++;
            assert ({A3, WD3} === got) else begin
               failures++;
               $error("FAIL wb_write observed rd=%0d data=%h expected rd=%0d data=%h",
                      A3, WD3, got[W-1:XLEN], got[XLEN-1:0]);
            end
         end
      end
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // directed stimulus
   initial begin
      int idx;
      logic rdy;
      logic [4:0] ld_rd [3];
      ld_rd = '{5'd3, 5'd4, 5'd6};

      rst = 1'b0;
      alu_valid = 0; alu_rd = 0; alu_data = 0;
      mem_valid = 0; mem_rd = 0; mem_data = 0;
      issue_valid = 0; issue_rd = 0; chk_a1 = 0; chk_a2 = 0;

      // reset state
      repeat (2) @(negedge clk);
      #1;
      chk("reset_we3", WE3, 0);
      chk("reset_a3", A3, 0);
      chk("reset_wd3", WD3, 0);
      chk("reset_ready", mem_ready, 0);
      @(negedge clk);
      rst = 1'b1;
      @(negedge clk);
      chk("ready_after_reset", mem_ready, 1);

      // ALU latency
      alu_valid = 1; alu_rd = 5'd9; alu_data = 32'h20;
      @(negedge clk);
      alu_valid = 0;
      chk("alu_we3_n1", WE3, 1);
      chk("alu_a3_n1", A3, 9);
      chk("alu_wd3_n1", WD3, 32'h20);
      @(negedge clk);
      chk("alu_we3_n2", WE3, 0);

      // priority and backpressure: ALU for 4 cycles, loads 3,4,6 back to back
      idx = 0;
      for (int c = 0; c < 12; c++) begin
         alu_valid = (c < 4);
         alu_rd    = 5'($urandom_range(10, 31));
         alu_data  = $urandom;
         mem_valid = (idx < 3);
         if (idx < 3) begin
            mem_rd   = ld_rd[idx];
            mem_data = 32'h100 + 32'(idx);
         end
         #1 rdy = mem_ready;
         if (c == 2 || c == 3) chk("bp_ready_low", mem_ready, 0);
         if (c == 5) chk("bp_ready_back", mem_ready, 1);
         @(negedge clk);
         if (mem_valid && rdy) idx++;
      end
      alu_valid = 0; mem_valid = 0;
      chk("bp_all_accepted", 64'(idx), 3);

      // scoreboard: issue 7, set wins over same-cycle pop, later pop clears
      issue_valid = 1; issue_rd = 5'd7;
      @(negedge clk);
      issue_valid = 0; chk_a1 = 5'd7; chk_a2 = 5'd7;
      #1;
      chk("sb_hazard_a1_set", hazard_a1, 1);
      chk("sb_hazard_a2_set", hazard_a2, 1);
      chk("sb_ready", mem_ready, 1);
      mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h77;
      @(negedge clk);
      mem_valid = 0; issue_valid = 1; issue_rd = 5'd7;
      #1 chk("sb_hazard_buffered", hazard_a1, 1);
      @(negedge clk);
      issue_valid = 0;
      #1 chk("sb_set_wins", hazard_a1, 1);
      mem_valid = 1; mem_rd = 5'd7; mem_data = 32'h78;
      @(negedge clk);
      mem_valid = 0;
      @(negedge clk);
      #1;
      chk("sb_cleared_a1", hazard_a1, 0);
      chk("sb_cleared_a2", hazard_a2, 0);

      // x0 suppression: ALU rd=0 fills the port while two rd=0 loads buffer
      chk_a1 = 5'd0; chk_a2 = 5'd0;
      issue_valid = 1; issue_rd = 5'd0;
      for (int c = 0; c < 6; c++) begin
         alu_valid = (c < 3); alu_rd = 5'd0; alu_data = 32'hDEADBEEF;
         mem_valid = (c < 2); mem_rd = 5'd0; mem_data = 32'hDEADBEEF;
         #1;
         if (c == 2) chk("x0_ready_full", mem_ready, 0);
         if (c == 1) chk("x0_hazard_a1", hazard_a1, 0);
         if (c == 5) chk("x0_ready_recover", mem_ready, 1);
         @(negedge clk);
         issue_valid = 0;
      end
      alu_valid = 0; mem_valid = 0;
      chk("x0_no_we3", WE3, 0);

      // wrap-around: 10 loads rd=1..10, data=rd*0x11
      idx = 0;
      for (int c = 0; c < 40 && idx < 10; c++) begin
         mem_valid = 1;
         mem_rd    = 5'(idx + 1);
         mem_data  = 32'((idx + 1) * 32'h11);
         #1 rdy = mem_ready;
         @(negedge clk);
         if (rdy) idx++;
      end
      mem_valid = 0;
      chk("wrap_all_accepted", 64'(idx), 10);
      repeat (3) @(negedge clk);

      // reset mid-stream: pending[5]=1 and two loads buffered
      issue_valid = 1; issue_rd = 5'd5;
      @(negedge clk);
      issue_valid = 0;
      idx = 0;
      for (int c = 0; c < 4; c++) begin
         alu_valid = 1; alu_rd = 5'd20; alu_data = $urandom;
         mem_valid = (idx < 2);
         mem_rd    = (idx == 0) ? 5'd5 : 5'd8;
         mem_data  = (idx == 0) ? 32'h55 : 32'h88;
         #1 rdy = mem_ready;
         @(negedge clk);
         if (mem_valid && rdy) idx++;
      end
      mem_valid = 0;
      chk_a1 = 5'd5;
      #1;
      chk("rst_pre_full", mem_ready, 0);
      chk("rst_pre_hazard", hazard_a1, 1);
      #2 rst = 1'b0;
      #1;
      chk("rst_we3", WE3, 0);
      chk("rst_a3", A3, 0);
      chk("rst_wd3", WD3, 0);
      chk("rst_ready", mem_ready, 0);
      chk("rst_hazard5", hazard_a1, 0);
      alu_valid = 0;
      @(negedge clk);
      rst = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk);
         chk("rst_no_write", WE3, 0);
      end
      chk("rst_hazard_after", hazard_a1, 0);
      chk("rst_ready_after", mem_ready, 1);

      repeat (2) @(negedge clk);
      chk("queue_drained", 64'(exp_q.size()), 0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
